comnet_master: RTL and testbench

- Initiator end of the comnet serial register link.
- Accepts one register transaction from the local host (rw, 8-bit address, 32-bit write data) and generates the SDa/SCl start condition, the 42-bit command frame, the turnaround/load clock and the stop condition.
- For reads it also clocks 32 bits back on RDa and presents them as rdata.
- Sits in the controller FPGA and drives the SDa/SCl pair of every TDC board's comnet slave.

---
 rtl/comnet_pkg.sv | 30 +++
 rtl/comnet_tick.sv | 31 +++
 rtl/comnet_master.sv | 162 ++++++++++++++++
 tb/tb_comnet_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comnet_pkg.sv
// comnet_pkg: definitions shared by the comnet master and slave.
//   FRAME_BITS : command frame length {0, rw, addr[7:0], wdata[31:0]}
//   RD_BITS    : read-return length
//   state_t    : transaction state encoding
//   pack_frame : builds the command frame; write data is zeroed for reads
package comnet_pkg;

    localparam int unsigned FRAME_BITS = 42;
    localparam int unsigned RD_BITS    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_TURN,
        ST_LOAD,
        ST_READ,
        ST_STOP,
        ST_DONE
    } state_t;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic        rw,
        input logic [7:0]  addr,
        input logic [31:0] wdata
    );
        return {1'b0, rw, addr, (rw ? 32'h0 : wdata)};
    endfunction

endpackage

// File: rtl/comnet_tick.sv
// comnet_tick: SCl half-period timer.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   en_i   : count while high; counter is held at 0 while low
//   tick_o : high on the last clk of each HALF-cycle half-period
module comnet_tick #(
    parameter int unsigned HALF = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CW'(HALF - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/comnet_master.sv
// comnet_master: initiator end of the comnet serial register link.
//   clk, rst          : system clock, asynchronous active-high reset
//   go, rw, addr,
//   wdata             : transaction request, latched when go is accepted in IDLE
//   busy, done        : busy from the cycle after accept; done pulses for one cycle
//   rdata             : read result, updated only at done of a read
//   SDa, SCl          : serial data / clock to the slave (idle high)
//   RDa               : serial return data from the slave
module comnet_master
    import comnet_pkg::*;
#(
    parameter int unsigned HALF = 4,
    parameter int unsigned TURN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        SDa,
    output logic        SCl,
    input  logic        RDa
);

    localparam int unsigned TW = $clog2(TURN + 1);

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic [RD_BITS-1:0]      cap_q;
    logic [5:0]              bit_q;
    logic [TW-1:0]           turn_q;
    logic                    sub_q;
    logic                    rw_q;
    logic                    tick;
    logic                    tick_en;

    // The timer is held off in TURN so LOAD starts on a full half-period.
    assign tick_en = (state_q == ST_START) || (state_q == ST_SHIFT) ||
                     (state_q == ST_LOAD)  || (state_q == ST_READ)  ||
                     (state_q == ST_STOP);

    comnet_tick #(.HALF(HALF)) u_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            cap_q   <= '0;
            bit_q   <= '0;
            turn_q  <= '0;
            sub_q   <= 1'b0;
            rw_q    <= 1'b0;
            SDa     <= 1'b1;
            SCl     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    SDa <= 1'b1;
                    SCl <= 1'b1;
                    if (go) begin
                        frame_q <= pack_frame(rw, addr, wdata);
                        rw_q    <= rw;
                        sub_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: if (tick) begin
                    if (!sub_q) begin
                        SDa   <= 1'b0;
                        sub_q <= 1'b1;
                    end else begin
                        SCl     <= 1'b0;
                        SDa     <= frame_q[FRAME_BITS-1];
                        frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                        bit_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                // bit_q counts rising edges; the frame ends on the falling tick after the 42nd.
                ST_SHIFT: if (tick) begin
                    if (!SCl) begin
                        SCl   <= 1'b1;
                        bit_q <= bit_q + 1'b1;
                    end else begin
                        SCl <= 1'b0;
                        if (bit_q == 6'(FRAME_BITS)) begin
                            SDa     <= 1'b0;
                            turn_q  <= '0;
                            state_q <= ST_TURN;
                        end else begin
                            SDa     <= frame_q[FRAME_BITS-1];
                            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_q == TW'(TURN - 1)) begin
                        state_q <= ST_LOAD;
                    end else begin
                        turn_q <= turn_q + 1'b1;
                    end
                end
                // Leaving on the falling tick: the low half-period is spent in the next state.
                ST_LOAD: if (tick) begin
                    if (!SCl) begin
                        SCl <= 1'b1;
                    end else begin
                        SCl     <= 1'b0;
                        bit_q   <= '0;
                        sub_q   <= 1'b0;
                        state_q <= rw_q ? ST_READ : ST_STOP;
                    end
                end
                // RDa is captured on the tick that ends the high phase.
                ST_READ: if (tick) begin
                    if (!SCl) begin
                        SCl   <= 1'b1;
                        bit_q <= bit_q + 1'b1;
                    end else begin
                        SCl   <= 1'b0;
                        cap_q <= {cap_q[RD_BITS-2:0], RDa};
                        if (bit_q == 6'(RD_BITS)) begin
                            sub_q   <= 1'b0;
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: if (tick) begin
                    if (!sub_q) begin
                        SCl   <= 1'b1;
                        sub_q <= 1'b1;
                    end else begin
                        SDa     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (rw_q) begin
                            rdata <= cap_q;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comnet_master.sv
// tb_comnet_master: table-driven and directed checks of comnet_master,
// with a line monitor/slave model for the default timing and a second
// instance at minimum timing (HALF=1, TURN=1).
module tb_comnet_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        go, rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic        SDa, SCl;
    logic        RDa = 1'b0;

    logic        go2, rw2;
    logic [7:0]  addr2;
    logic [31:0] wdata2;
    logic        busy2, done2;
    logic [31:0] rdata2;
    logic        SDa2, SCl2;
    logic        RDa2 = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    comnet_master #(.HALF(4), .TURN(16)) u_dut (
        .clk(clk), .rst(rst), .go(go), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .SDa(SDa), .SCl(SCl), .RDa(RDa)
    );

    comnet_master #(.HALF(1), .TURN(1)) u_min (
        .clk(clk), .rst(rst), .go(go2), .rw(rw2), .addr(addr2), .wdata(wdata2),
        .busy(busy2), .done(done2), .rdata(rdata2), .SDa(SDa2), .SCl(SCl2), .RDa(RDa2)
    );

    // ---------------- line monitor + slave model (main instance) ----------------
    int unsigned cyc = 0;
    logic        pscl = 1'b1, psda = 1'b1;
    bit          in_frame = 0, seen_rise = 0;
    int unsigned m_rises = 0, m_pulses = 0, m_starts = 0, m_stops = 0;
    int unsigned m_viol = 0, m_gap = 0, m_fall = 0;
    logic [41:0] m_frame = '0;
    logic [31:0] slave_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame  = 0;
            seen_rise = 0;
            m_rises   = 0;
            pscl      = 1'b1;
            psda      = 1'b1;
        end else begin
            if (pscl && SCl && (psda !== SDa)) begin
                if (!SDa && !in_frame) begin
                    in_frame  = 1;
                    seen_rise = 0;
                    m_starts++;
                    m_rises   = 0;
                    m_pulses  = 0;
                    m_stops   = 0;
                    m_gap     = 0;
                    m_frame   = '0;
                end else if (SDa && in_frame) begin
                    in_frame = 0;
                    m_stops++;
                end else begin
                    m_viol++;
                end
            end
            if (!pscl && SCl) begin
                m_rises++;
                seen_rise = 1;
                if (m_rises <= 42) m_frame = {m_frame[40:0], SDa};
                if (m_rises == 43) m_gap = cyc - m_fall;
                if (m_rises >= 44 && m_rises <= 75) RDa = slave_data[75 - m_rises];
            end
            if (pscl && !SCl) begin
                m_fall = cyc;
                if (seen_rise) m_pulses++;
                seen_rise = 0;
            end
            pscl = SCl;
            psda = SDa;
        end
    end

    // ---------------- slave model (minimum-timing instance) ----------------
    logic        pscl2 = 1'b1;
    bit          seen2 = 0;
    int unsigned m2_rises = 0, m2_pulses = 0, m2_final = 0;
    logic [31:0] d2 = '0;

    always @(negedge clk) begin
        if (done2) m2_final = m2_pulses;
        if (!busy2) begin
            m2_rises  = 0;
            m2_pulses = 0;
            seen2     = 0;
        end else begin
            if (!pscl2 && SCl2) begin
                m2_rises++;
                seen2 = 1;
                if (m2_rises >= 44 && m2_rises <= 75) RDa2 = d2[75 - m2_rises];
            end
            if (pscl2 && !SCl2 && seen2) begin
                m2_pulses++;
                seen2 = 0;
            end
        end
        pscl2 = SCl2;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [41:0] frame;
        int unsigned pulses;
        logic [31:0] rdata;
    } vec_t;

    task automatic check_done_state(input string nm, input vec_t v);
        chk({nm, "_frame"},  64'(m_frame),  64'(v.frame));
        chk({nm, "_pulses"}, 64'(m_pulses), 64'(v.pulses));
        chk({nm, "_stops"},  64'(m_stops),  64'd1);
        chk({nm, "_viol"},   64'(m_viol),   64'd0);
        chk({nm, "_rdata"},  64'(rdata),    64'(v.rdata));
        chk({nm, "_busy"},   64'(busy),     64'd0);
        checks++;
        if (m_gap < 16) begin
            errors++;
            $display("FAIL %s_load_gap actual=%0d required>=16", nm, m_gap);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int unsigned s0;
        bit ok;
        slave_data = v.sdata;
        s0 = m_starts;
        @(negedge clk); #1;
        rw = v.rw; addr = v.addr; wdata = v.wdata; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        chk({nm, "_busy_go"}, 64'(busy), 64'd1);
        wait_done(ok);
        chk({nm, "_done_seen"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({nm, "_starts"}, 64'(m_starts - s0), 64'd1);
            check_done_state(nm, v);
            @(negedge clk); #1;
            chk({nm, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int unsigned s0;
        vec_t        w;

        vecs[0] = '{1'b0, 8'h5A, 32'h12345678, 32'h0,        42'h05A12345678, 43, 32'h0};
        vecs[1] = '{1'b1, 8'h03, 32'hCAFEF00D, 32'hDEADBEEF, 42'h10300000000, 75, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'hFF, 32'hFFFFFFFF, 32'h0,        42'h0FFFFFFFFFF, 43, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 8'h80, 32'h0,        32'hA5A5A5A5, 42'h18000000000, 75, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 8'h01, 32'h80000001, 32'h0,        42'h00180000001, 43, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 8'h3C, 32'h0,        32'h00000001, 42'h13C00000000, 75, 32'h00000001};

        rst = 1'b1; go = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        go2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_SDa",   64'(SDa),   64'd1);
        chk("rst_SCl",   64'(SCl),   64'd1);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of SHIFT, then a clean frame.
        slave_data = '0;
        @(negedge clk); #1;
        rw = 1'b0; addr = 8'h5A; wdata = 32'h12345678; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (m_rises == 20) begin
                ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("midrst_reach_bit20", 64'(ok), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_SDa",   64'(SDa),   64'd1);
        chk("midrst_SCl",   64'(SCl),   64'd1);
        chk("midrst_busy",  64'(busy),  64'd0);
        chk("midrst_rdata", 64'(rdata), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        w = vecs[0];
        run_vec("after_rst", w);

        // go held high: one transaction per IDLE entry, no queuing.
        w = '{1'b0, 8'h42, 32'h0BADF00D, 32'h0, 42'h0420BADF00D, 43, 32'h0};
        @(negedge clk); #1;
        rw = w.rw; addr = w.addr; wdata = w.wdata; go = 1'b1;
        wait_done(ok);
        chk("cont1_done_seen", 64'(ok), 64'd1);
        if (ok) begin
            check_done_state("cont1", w);
            s0 = m_starts;
            @(negedge clk); #1;
            chk("cont_idle_gap_busy", 64'(busy), 64'd0);
            @(negedge clk); #1;
            chk("cont_reaccept_busy", 64'(busy), 64'd1);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk); #1;
                go = ~go;
            end
            go = 1'b0;
            wait_done(ok);
            chk("cont2_done_seen", 64'(ok), 64'd1);
            if (ok) begin
                chk("cont2_starts", 64'(m_starts - s0), 64'd1);
                check_done_state("cont2", w);
                s0 = m_starts;
                repeat (60) @(negedge clk);
                #1;
                chk("cont_no_queue_starts", 64'(m_starts - s0), 64'd0);
                chk("cont_no_queue_busy",   64'(busy),           64'd0);
            end
        end

        // Minimum timing read on the second instance.
        d2 = 32'hA5A5A5A5;
        @(negedge clk); #1;
        rw2 = 1'b1; addr2 = 8'h55; wdata2 = 32'h0; go2 = 1'b1;
        @(negedge clk); #1;
        go2 = 1'b0;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (done2) begin
                ok = 1;
                break;
            end
        end
        chk("min_done_seen", 64'(ok), 64'd1);
        if (ok) begin
            chk("min_rdata",  64'(rdata2),   64'hA5A5A5A5);
            chk("min_pulses", 64'(m2_final), 64'd75);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
